// File: rtl/sys_pkg.sv
// Shared definitions for the systolic-array job controller.
//   - Register addresses of the array control block (start, max counter, run counter).
//   - Controller FSM state type.
//   - is_ctrl_reg(): true for addresses in the protected control register window.
package sys_pkg;

    localparam logic [15:0] SYS_START_ADR = 16'hFFF0;
    localparam logic [15:0] SYS_MAX_CNTR  = 16'hFFF1;
    localparam logic [15:0] SYS_RUN_CNTR  = 16'hFFF2;

    typedef enum logic [2:0] {
        StIdle,
        StWrMax,
        StWrRun,
        StWrStart,
        StWaitBusy,
        StWaitDone,
        StDone
    } sys_state_e;

    function automatic logic is_ctrl_reg(input logic [15:0] adr);
        return (adr >= SYS_START_ADR) && (adr <= SYS_RUN_CNTR);
    endfunction

endpackage

// File: rtl/sys_ctrl_wdog.sv
// Watchdog counter for the job controller's wait phase.
// Ports:
//   clk      clock, posedge
//   rst      synchronous active-high reset
//   clr      restart the count from zero
//   en       count one cycle
//   expired  high in the cycle the count sits at TIMEOUT_CYC-1 while counting
module sys_ctrl_wdog #(
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYC - 1);

    logic [15:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign expired = en && (cnt_q == LIMIT);

endmodule

// File: rtl/sys_ctrl.sv
// Job controller for the systolic array. Accepts a job descriptor, programs the max and run
// counters, issues job_cnt start pulses (each waiting for the array to go busy then idle) and
// pulses done. Shares the buffer write port with a host, which is stalled while the
// controller writes and, during a job, on accesses to the control registers.
// Optional feature: define SYS_CTRL_TIMEOUT_EN for a wait-phase watchdog that aborts the job
// after TIMEOUT_CYC cycles and pulses err.
// Ports:
//   clk, rst                      clock and synchronous active-high reset
//   job_valid/job_ready           job handshake (ready only in idle)
//   job_max, job_run, job_cnt     max-counter value, run-counter value, pass count (0 -> 1)
//   h_wen, h_wadr, h_wdata        host write request; h_stall asks the host to hold it
//   wen, wadr, wdata              arbitrated write port toward the buffer block
//   sys_busy                      array running
//   busy, done, err               job in progress, completion pulse, watchdog abort pulse
module sys_ctrl
    import sys_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        job_valid,
    output logic        job_ready,
    input  logic [7:0]  job_max,
    input  logic [7:0]  job_run,
    input  logic [7:0]  job_cnt,
    input  logic        h_wen,
    input  logic [15:0] h_wadr,
    input  logic [15:0] h_wdata,
    output logic        h_stall,
    output logic        wen,
    output logic [15:0] wadr,
    output logic [15:0] wdata,
    input  logic        sys_busy,
    output logic        busy,
    output logic        done,
    output logic        err
);

    if (TIMEOUT_CYC < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 2");
    end

    sys_state_e  state_q;
    logic [7:0]  max_q;
    logic [7:0]  run_q;
    logic [7:0]  remaining_q;

`ifdef SYS_CTRL_TIMEOUT_EN
    logic wdog_expired;
    logic err_q;

    // Clearing in WR_START makes every WAIT_BUSY entry start from zero.
    sys_ctrl_wdog #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (state_q == StWrStart),
        .en      ((state_q == StWaitBusy) || (state_q == StWaitDone)),
        .expired (wdog_expired)
    );

    assign err = ~rst & err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            max_q       <= '0;
            run_q       <= '0;
            remaining_q <= '0;
`ifdef SYS_CTRL_TIMEOUT_EN
            err_q       <= 1'b0;
`endif
        end else begin
`ifdef SYS_CTRL_TIMEOUT_EN
            err_q <= 1'b0;
`endif
            unique case (state_q)
                StIdle: begin
                    if (job_valid) begin
                        max_q       <= job_max;
                        run_q       <= job_run;
                        remaining_q <= (job_cnt == 8'd0) ? 8'd1 : job_cnt;
                        state_q     <= StWrMax;
                    end
                end
                StWrMax:   state_q <= StWrRun;
                StWrRun:   state_q <= StWrStart;
                StWrStart: state_q <= StWaitBusy;
                StWaitBusy: begin
`ifdef SYS_CTRL_TIMEOUT_EN
                    if (wdog_expired) begin
                        state_q <= StIdle;
                        err_q   <= 1'b1;
                    end else
`endif
                    // A zero run count never makes the array busy, so don't wait for it.
                    if (sys_busy || (run_q == 8'd0)) begin
                        state_q <= StWaitDone;
                    end
                end
                StWaitDone: begin
`ifdef SYS_CTRL_TIMEOUT_EN
                    if (wdog_expired) begin
                        state_q <= StIdle;
                        err_q   <= 1'b1;
                    end else
`endif
                    if (!sys_busy) begin
                        remaining_q <= remaining_q - 8'd1;
                        state_q     <= (remaining_q == 8'd1) ? StDone : StWrStart;
                    end
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    logic in_job;
    logic host_blocked;

    assign in_job       = (state_q != StIdle);
    assign host_blocked = (state_q == StWrMax) || (state_q == StWrRun) ||
                          (state_q == StWrStart) || (in_job && is_ctrl_reg(h_wadr));

    always_comb begin
        job_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        h_stall   = 1'b0;
        wen       = 1'b0;
        wadr      = '0;
        wdata     = '0;
        if (!rst) begin
            job_ready = ~in_job;
            busy      = in_job;
            done      = (state_q == StDone);
            h_stall   = h_wen & host_blocked;
            unique case (state_q)
                StWrMax: begin
                    wen   = 1'b1;
                    wadr  = SYS_MAX_CNTR;
                    wdata = {8'h00, max_q};
                end
                StWrRun: begin
                    wen   = 1'b1;
                    wadr  = SYS_RUN_CNTR;
                    wdata = {8'h00, run_q};
                end
                StWrStart: begin
                    wen   = 1'b1;
                    wadr  = SYS_START_ADR;
                    wdata = 16'h0001;
                end
                default: begin
                    if (h_wen && !host_blocked) begin
                        wen   = 1'b1;
                        wadr  = h_wadr;
                        wdata = h_wdata;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sys_ctrl.sv
`timescale 1ns/1ps
module tb_sys_ctrl;

    localparam int unsigned TO = 16;
`ifdef SYS_CTRL_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        job_valid = 1'b0;
    logic        job_ready;
    logic [7:0]  job_max = '0;
    logic [7:0]  job_run = '0;
    logic [7:0]  job_cnt = '0;
    logic        h_wen = 1'b0;
    logic [15:0] h_wadr = '0;
    logic [15:0] h_wdata = '0;
    logic        h_stall;
    logic        wen;
    logic [15:0] wadr;
    logic [15:0] wdata;
    logic        sys_busy = 1'b0;
    logic        busy;
    logic        done;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sys_ctrl #(
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .job_valid (job_valid),
        .job_ready (job_ready),
        .job_max   (job_max),
        .job_run   (job_run),
        .job_cnt   (job_cnt),
        .h_wen     (h_wen),
        .h_wadr    (h_wadr),
        .h_wdata   (h_wdata),
        .h_stall   (h_stall),
        .wen       (wen),
        .wadr      (wadr),
        .wdata     (wdata),
        .sys_busy  (sys_busy),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    // Reference model: a job is a queue of pending controller writes followed by a wait
    // phase per pass; the write at the queue head is what the port must show this cycle.
    bit          m_valid = 0;
    bit          m_active, m_seen, m_done, m_err;
    int          m_left, m_wd;
    logic [7:0]  m_run;
    logic [31:0] m_wq[$];

    logic        e_wen, e_stall, e_busy, e_done, e_err, e_rdy, blk, ok;
    logic [15:0] e_adr, e_dat;

    always @(negedge clk) begin
        if (m_valid || rst) begin
            e_wen = 0; e_stall = 0; e_busy = 0; e_done = 0; e_err = 0; e_rdy = 0;
            e_adr = '0; e_dat = '0;
            if (!rst) begin
                e_busy = m_active;
                e_rdy  = !m_active;
                e_done = m_done;
                e_err  = m_err;
                if (m_active && m_wq.size() > 0) begin
                    e_wen   = 1'b1;
                    e_adr   = m_wq[0][31:16];
                    e_dat   = m_wq[0][15:0];
                    e_stall = h_wen;
                end else begin
                    blk     = m_active && (h_wadr >= 16'hFFF0) && (h_wadr <= 16'hFFF2);
                    e_stall = h_wen && blk;
                    e_wen   = h_wen && !blk;
                    e_adr   = h_wadr;
                    e_dat   = h_wdata;
                end
            end
            ok = (wen === e_wen) && (h_stall === e_stall) && (busy === e_busy) &&
                 (done === e_done) && (err === e_err) && (job_ready === e_rdy) &&
                 (!(e_wen || rst) || ((wadr === e_adr) && (wdata === e_dat)));
            n_tests++;
            if (!ok) begin
                n_fail++;
                $display("FAIL cycle_model t=%0t got wen=%b adr=%h dat=%h stall=%b busy=%b done=%b err=%b rdy=%b want wen=%b adr=%h dat=%h stall=%b busy=%b done=%b err=%b rdy=%b",
                         $time, wen, wadr, wdata, h_stall, busy, done, err, job_ready,
                         e_wen, e_adr, e_dat, e_stall, e_busy, e_done, e_err, e_rdy);
            end
        end
        // Advance the model with the inputs the DUT samples at the coming edge.
        if (rst) begin
            m_valid = 1; m_active = 0; m_seen = 0; m_done = 0; m_err = 0;
            m_left = 0; m_wd = 0; m_run = '0;
            m_wq.delete();
        end else if (m_valid) begin
            m_err = 0;
            if (!m_active) begin
                if (job_valid) begin
                    m_active = 1;
                    m_run    = job_run;
                    m_left   = (job_cnt == 0) ? 1 : int'(job_cnt);
                    m_wq.push_back({16'hFFF1, 8'h00, job_max});
                    m_wq.push_back({16'hFFF2, 8'h00, job_run});
                    m_wq.push_back({16'hFFF0, 16'h0001});
                end
            end else if (m_done) begin
                m_active = 0;
                m_done   = 0;
            end else if (m_wq.size() > 0) begin
                void'(m_wq.pop_front());
                if (m_wq.size() == 0) begin
                    m_seen = 0;
                    m_wd   = 0;
                end
            end else if (TO_EN && m_wd == int'(TO) - 1) begin
                m_active = 0;
                m_err    = 1;
            end else begin
                if (!m_seen) begin
                    if (sys_busy || m_run == 0) m_seen = 1;
                end else if (!sys_busy) begin
                    m_left--;
                    if (m_left == 0) m_done = 1;
                    else m_wq.push_back({16'hFFF0, 16'h0001});
                end
                m_wd++;
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Runs one job with a responder holding sys_busy for 3 cycles after each start write.
    task automatic run_job(input logic [7:0] mx, input logic [7:0] rn, input logic [7:0] ct,
                           output int starts, output int dones);
        int cd;
        starts = 0; dones = 0; cd = 0;
        nxt();
        job_valid = 1; job_max = mx; job_run = rn; job_cnt = ct;
        nxt();
        job_valid = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (wen && wadr == 16'hFFF0) begin
                starts++;
                cd = 3;
            end
            if (done) begin
                dones++;
                break;
            end
            if (err) break;
            nxt();
            sys_busy = (cd > 0);
            if (cd > 0) cd--;
        end
        sys_busy = 0;
    endtask

    int st, dn;

    initial begin
        // Reset behaviour.
        rst = 1;
        nxt(); nxt();
        @(negedge clk);
        chk("rst_ready", {31'd0, job_ready}, 32'd0);
        chk("rst_wen", {31'd0, wen}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        nxt();
        rst = 0;
        @(negedge clk);
        chk("ready_after_rst", {31'd0, job_ready}, 32'd1);

        // Single pass job with host traffic.
        nxt();
        job_valid = 1; job_max = 8'h10; job_run = 8'h04; job_cnt = 8'd1;
        @(negedge clk);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        nxt();
        job_valid = 0;
        @(negedge clk);
        chk("wr_max", {wadr, wdata}, 32'hFFF1_0010);
        chk("wr_max_busy", {31'd0, busy}, 32'd1);
        nxt();
        h_wen = 1; h_wadr = 16'h0405; h_wdata = 16'hBEEF;
        @(negedge clk);
        chk("wr_run", {wadr, wdata}, 32'hFFF2_0004);
        chk("wr_run_stall", {31'd0, h_stall}, 32'd1);
        nxt();
        h_wen = 0;
        @(negedge clk);
        chk("wr_start", {15'd0, wen, wadr}, {15'd0, 1'b1, 16'hFFF0});
        nxt();
        sys_busy = 1;
        @(negedge clk);
        chk("wait_busy_wen", {31'd0, wen}, 32'd0);
        nxt();
        h_wen = 1; h_wadr = 16'h0405; h_wdata = 16'hBEEF;
        @(negedge clk);
        chk("host_pass", {15'd0, wen, wadr}, {15'd0, 1'b1, 16'h0405});
        chk("host_pass_stall", {31'd0, h_stall}, 32'd0);
        nxt();
        h_wadr = 16'hFFF0; h_wdata = 16'h1234;
        @(negedge clk);
        chk("host_ctrl_stall", {30'd0, h_stall, wen}, 32'd2);
        nxt();
        @(negedge clk);
        chk("host_ctrl_stall2", {31'd0, h_stall}, 32'd1);
        nxt();
        sys_busy = 0;
        @(negedge clk);
        chk("no_early_done", {31'd0, done}, 32'd0);
        nxt();
        @(negedge clk);
        chk("done_pulse", {30'd0, done, h_stall}, 32'd3);
        nxt();
        @(negedge clk);
        chk("after_done", {30'd0, done, busy}, 32'd0);
        chk("host_fwd_idle", {wen, h_stall, wadr, wdata[13:0]}, {1'b1, 1'b0, 16'hFFF0, 14'h1234});
        nxt();
        h_wen = 0;

        // Multi-pass jobs.
        run_job(8'h20, 8'h03, 8'd3, st, dn);
        chk("cnt3_starts", st, 32'd3);
        chk("cnt3_dones", dn, 32'd1);
        run_job(8'h01, 8'h02, 8'd0, st, dn);
        chk("cnt0_starts", st, 32'd1);
        chk("cnt0_dones", dn, 32'd1);
        run_job(8'h07, 8'h00, 8'd2, st, dn);
        chk("run0_starts", st, 32'd2);

        // Reset in the middle of a job.
        nxt();
        job_valid = 1; job_max = 8'h22; job_run = 8'h05; job_cnt = 8'd2;
        nxt();
        job_valid = 0;
        nxt(); nxt();
        nxt();
        sys_busy = 1;
        nxt();
        @(negedge clk);
        chk("mid_busy", {31'd0, busy}, 32'd1);
        nxt();
        rst = 1;
        @(negedge clk);
        chk("mid_rst_outs", {wen, h_stall, busy, done, err, job_ready, wadr, wdata[9:0]}, 32'd0);
        nxt();
        rst = 0; sys_busy = 0;
        @(negedge clk);
        chk("post_rst", {29'd0, busy, done, job_ready}, 32'd1);
        run_job(8'h33, 8'h02, 8'd1, st, dn);
        chk("post_rst_job", {st[15:0], dn[15:0]}, {16'd1, 16'd1});

`ifdef SYS_CTRL_TIMEOUT_EN
        // Watchdog abort with the array stuck busy.
        nxt();
        job_valid = 1; job_max = 8'h10; job_run = 8'h04; job_cnt = 8'd1;
        nxt();
        job_valid = 0;
        nxt(); nxt();
        nxt();
        sys_busy = 1;
        for (int k = 1; k <= 15; k++) begin
            nxt();
            @(negedge clk);
            if (k == 15) chk("to_before", {30'd0, busy, err}, 32'd2);
        end
        nxt();
        @(negedge clk);
        chk("to_err", {29'd0, err, busy, done}, 32'd4);
        nxt();
        sys_busy = 0;
        @(negedge clk);
        chk("to_err_once", {31'd0, err}, 32'd0);
`endif

        // Randomized traffic checked by the model.
        for (int i = 0; i < 4000; i++) begin
            nxt();
            rst       = ($urandom_range(0, 299) == 0);
            job_valid = ($urandom_range(0, 3) == 0);
            job_max   = 8'($urandom);
            job_run   = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
            job_cnt   = 8'($urandom_range(0, 3));
            h_wen     = 1'($urandom_range(0, 1));
            h_wadr    = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(16'hFFEF, 16'hFFF3))
                                                    : 16'($urandom);
            h_wdata   = 16'($urandom);
            if ($urandom_range(0, 3) == 0) sys_busy = ~sys_busy;
        end
        nxt();
        rst = 0; h_wen = 0; job_valid = 0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
